// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, instruction format enum and the encoded-entry payload.
package instr_encoder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    localparam logic [OPC_W-1:0] OP_ALU    = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_ALUI   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        NULL,
        FORMAT_R,
        FORMAT_I,
        FORMAT_S,
        FORMAT_B,
        FORMAT_U,
        FORMAT_J
    } format_t;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic            err;
    } enc_entry_t;

    // Instruction format selected by the opcode; NULL marks an illegal opcode.
    function automatic format_t opcode_format(input logic [OPC_W-1:0] opcode);
        format_t fmt;
        case (opcode)
            OP_ALU:                     fmt = FORMAT_R;
            OP_ALUI, OP_LOAD, OP_JALR:  fmt = FORMAT_I;
            OP_STORE:                   fmt = FORMAT_S;
            OP_BRANCH:                  fmt = FORMAT_B;
            OP_JAL:                     fmt = FORMAT_J;
            OP_LUI, OP_AUIPC:           fmt = FORMAT_U;
            default:                    fmt = NULL;
        endcase
        return fmt;
    endfunction

    // True when v is a sign extension of its low (msb+1) bits.
    function automatic logic sext_fits(input logic [XLEN-1:0] v, input int unsigned msb);
        logic [XLEN-1:0] sh;
        sh = XLEN'($signed(v) >>> msb);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range/alignment checking.
// Ports: opcode/rd/rs1/rs2/f3/f7/imm fields in; ir_c encoded word (0 on error), err_c unencodable flag.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [F3_W-1:0]  f3,
    input  logic [F7_W-1:0]  f7,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  ir_c,
    output logic             err_c
);

    format_t         fmt;
    logic [XLEN-1:0] word;
    logic            legal;

    // Select format, build the word and decide legality.
    always_comb begin
        fmt   = opcode_format(opcode);
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FORMAT_R: begin
                word  = {f7, rs2, rs1, f3, rd, opcode};
                legal = 1'b1;
            end
            FORMAT_I: begin
                // Immediate shifts carry f7 above a 5-bit shamt.
                if ((opcode == OP_ALUI) && ((f3 == 3'b001) || (f3 == 3'b101))) begin
                    word  = {f7, imm[4:0], rs1, f3, rd, opcode};
                    legal = (imm[XLEN-1:5] == '0);
                end else begin
                    word  = {imm[11:0], rs1, f3, rd, opcode};
                    legal = sext_fits(imm, 11);
                end
            end
            FORMAT_S: begin
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
                legal = sext_fits(imm, 11);
            end
            FORMAT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
                legal = sext_fits(imm, 12) && !imm[0];
            end
            FORMAT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == '0);
            end
            FORMAT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = sext_fits(imm, 20) && !imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
        err_c = !legal;
        ir_c  = legal ? word : '0;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs an accepted field bundle into a 2-entry output FIFO.
// Ports: clk, rst_n; in_valid/in_ready + instruction fields; out_valid/out_ready,
//        ir (encoded word), err (entry unencodable), enc_count (delivered words).
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [F3_W-1:0]  f3,
    input  logic [F7_W-1:0]  f7,
    input  logic [XLEN-1:0]  imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ir,
    output logic             err,
    output logic [XLEN-1:0]  enc_count
);

    localparam int unsigned CNT_W = 2;

    enc_entry_t      new_entry;
    enc_entry_t      slot0_q, slot0_d;
    enc_entry_t      slot1_q, slot1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            in_ready_d, out_valid_d;
    logic [XLEN-1:0] enc_count_d;
    logic            push, pop;

    instr_pack u_pack (
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .f3     (f3),
        .f7     (f7),
        .imm    (imm),
        .ir_c   (new_entry.ir),
        .err_c  (new_entry.err)
    );

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // slot0 is always the head so ir/err come straight from a register.
    always_comb begin
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        count_d     = count_q;
        enc_count_d = enc_count;
        case ({push, pop})
            2'b10: begin
                if (count_q == '0) slot0_d = new_entry;
                else               slot1_d = new_entry;
                count_d = CNT_W'(count_q + CNT_W'(1));
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = CNT_W'(count_q - CNT_W'(1));
            end
            2'b11: begin
                // Only reachable at occupancy 1: head replaced, occupancy kept.
                slot0_d = new_entry;
            end
            default: ;
        endcase
        if (pop) enc_count_d = XLEN'(enc_count + XLEN'(1));
        in_ready_d  = (count_d < CNT_W'(2));
        out_valid_d = (count_d != '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q   <= '0;
            slot1_q   <= '0;
            count_q   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            enc_count <= '0;
        end else begin
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            count_q   <= count_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            enc_count <= enc_count_d;
        end
    end

    assign ir  = slot0_q.ir;
    assign err = slot0_q.err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, backpressure, reset, random traffic.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ir;
    logic        err;
    logic [31:0] enc_count;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .f3        (f3),
        .f7        (f7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ir        (ir),
        .err       (err),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] sb[$];          // {err, ir} in acceptance order
    logic [31:0] exp_count = '0;
    bit          rnd_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Reference encoder written directly from the format rules with integer ranges.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] fn3, input logic [6:0] fn7,
                                          input logic [31:0] im);
        int signed   si;
        bit          ok;
        logic [31:0] w;
        si = im;
        ok = 1'b0;
        w  = '0;
        case (op)
            7'b0110011: begin ok = 1'b1; w = {fn7, s2, s1, fn3, d, op}; end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (op == 7'b0010011 && (fn3 == 3'd1 || fn3 == 3'd5)) begin
                    ok = (si >= 0) && (si <= 31);
                    w  = {fn7, im[4:0], s1, fn3, d, op};
                end else begin
                    ok = (si >= -2048) && (si <= 2047);
                    w  = {im[11:0], s1, fn3, d, op};
                end
            end
            7'b0100011: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = {im[11:5], s2, s1, fn3, im[4:0], op};
            end
            7'b1100011: begin
                ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
                w  = {im[12], im[10:5], s2, s1, fn3, im[4:1], im[11], op};
            end
            7'b1101111: begin
                ok = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
                w  = {im[20], im[10:1], im[11], im[19:12], d, op};
            end
            7'b0110111, 7'b0010111: begin
                ok = (im % 4096) == 0;
                w  = {im[31:12], d, op};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0};
    endfunction

    // Offer one bundle until accepted; the expected response is queued at acceptance.
    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic [31:0] im, input logic [32:0] exp);
        int n = 0;
        bit done = 1'b0;
        opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) begin
                n++;
                if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
                if (n > 100) begin
                    fail_now("send_accept");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) fail_now("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares each delivered word, the counter, and hold stability.
    logic        held = 1'b0;
    logic [32:0] held_word;
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            chk("enc_count", 64'(enc_count), 64'(exp_count));
            if (held) chk("hold_stable", 64'({err, ir}), 64'(held_word));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    chk("err", 64'(err), 64'(e[32]));
                    chk("ir", 64'(ir), 64'(e[31:0]));
                end
                exp_count = exp_count + 32'd1;
            end
            held      = out_valid && !out_ready;
            held_word = {err, ir};
        end
    end

    localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                       7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                       7'b0010111};

    initial begin
        logic [6:0]  op;
        logic [4:0]  d, s1, s2;
        logic [2:0]  fn3;
        logic [6:0]  fn7;
        logic [31:0] im;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_enc_count", 64'(enc_count), 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed encodings.
        out_ready = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, {1'b0, 32'h00500093});
        chk("addi_latency_valid", 64'(out_valid), 64'd1);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, {1'b0, 32'h0020A423});
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, {1'b0, 32'h008000EF});
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, {1'b0, 32'h123452B7});
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, {1'b1, 32'h0});
        send(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b001, 7'd0, 32'd32, {1'b1, 32'h0});
        send(7'b1111111, 5'd3, 5'd4, 5'd0, 3'b000, 7'd0, 32'd0, {1'b1, 32'h0});
        drain();
        chk("enc_count_directed", 64'(enc_count), 64'd7);

        // Reset with two entries queued.
        out_ready = 1'b0;
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 7'd0, 32'd0, {1'b0, 32'h003100B3});
        send(7'b0110011, 5'd4, 5'd5, 5'd6, 3'b000, 7'h20, 32'd0, {1'b0, 32'h40628233});
        chk("two_queued_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        sb.delete();
        exp_count = '0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_enc_count", 64'(enc_count), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
        chk("midrst_no_output", 64'(out_valid), 64'd0);

        // Backpressure: third bundle must wait until the head is taken.
        send(7'b0010011, 5'd7, 5'd8, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, model(7'b0010011, 5'd7, 5'd8, 5'd0, 3'b000, 7'd0, 32'hFFFFF800));
        send(7'b0000011, 5'd9, 5'd10, 5'd0, 3'b010, 7'd0, 32'd2047, model(7'b0000011, 5'd9, 5'd10, 5'd0, 3'b010, 7'd0, 32'd2047));
        opcode = 7'b1100011; rd = 5'd0; rs1 = 5'd11; rs2 = 5'd12; f3 = 3'b001; f7 = 7'd0; imm = 32'hFFFFF000;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(7'b1100011, 5'd0, 5'd11, 5'd12, 3'b001, 7'd0, 32'hFFFFF000, model(7'b1100011, 5'd0, 5'd11, 5'd12, 3'b001, 7'd0, 32'hFFFFF000));
        drain();
        chk("bp_enc_count", 64'(enc_count), 64'd3);

        // Random traffic against the reference model.
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            op = (k == 9) ? 7'($urandom) : OPS[k];
            d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
            fn3 = 3'($urandom); fn7 = 7'($urandom);
            case ($urandom_range(0, 4))
                0: im = 32'($urandom_range(0, 63)) - 32'd32;
                1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: im = $urandom;
                3: im = $urandom & 32'hFFFFF000;
                default: im = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            send(op, d, s1, s2, fn3, fn7, im, model(op, d, s1, s2, fn3, fn7, im));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_mode = 1'b0;
        drain();
        chk("final_enc_count", 64'(enc_count), 64'(exp_count));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
